// File: rtl/cpu_pkg.sv
// Shared fetch-unit definitions.
//   fetch_state_t : fetch sequencer states
//   PC_INC        : default byte increment of the PC per sequential fetch
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_INC = 32'd4;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word and its fetch address.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_i            : capture instr_i/pc_i (entry becomes valid)
//   pop_i             : entry has been moved out (entry becomes empty)
//   flush_i           : discard the entry (dominates load and pop)
//   instr_i, pc_i     : data to capture
//   valid_o           : entry holds data
//   instr_o, pc_o     : buffered instruction and its address
module fetch_skid #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_q;

  // Skid entry register: flush beats load, load beats pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Handshake-aware instruction fetch unit. Owns the PC, issues req/ack
// fetches, buffers returned words in an output slot plus one skid entry,
// and applies redirects (dominant) and decode stalls.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req/imem_addr               : fetch request (held until imem_ack)
//   imem_ack/imem_rdata              : acknowledge with same-cycle data
//   redirect_valid/redirect_target   : branch/jump redirect pulse and target
//   stall                            : decode cannot accept the slot
//   instr_valid/instr/instr_pc       : output slot to decode
//   pc_out                           : next address to request
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned           INSTR_BYTES = PC_INC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] pc_out
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;

  logic                  consume_s;
  logic                  pc_advance_s;
  logic                  skid_load_s, skid_pop_s, skid_flush_s;
  logic                  skid_valid_s;
  logic [DATA_WIDTH-1:0] skid_instr_s, skid_pc_s;
  logic [DATA_WIDTH-1:0] pc_inc_s, redirect_pc_s;

  assign consume_s     = instr_valid_q & ~stall;
  assign pc_inc_s      = pc_q + DATA_WIDTH'(INSTR_BYTES);  // wraps silently
  assign redirect_pc_s = {redirect_target[DATA_WIDTH-1:2], 2'b00};

  fetch_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load_s),
    .pop_i   (skid_pop_s),
    .flush_i (skid_flush_s),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .valid_o (skid_valid_s),
    .instr_o (skid_instr_s),
    .pc_o    (skid_pc_s)
  );

  // PC next-value: redirect target vs. sequential increment, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc_s;
    end else if (pc_advance_s) begin
      pc_d = pc_inc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Next-state, slot and skid control.
  always_comb begin
    state_d       = state_q;
    drain_addr_d  = drain_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q & ~consume_s;
    pc_advance_s  = 1'b0;
    skid_load_s   = 1'b0;
    skid_pop_s    = 1'b0;
    skid_flush_s  = 1'b0;

    if (redirect_valid) begin
      instr_valid_d = 1'b0;
      skid_flush_s  = 1'b1;
      case (state_q)
        REQ: begin
          if (imem_ack) begin
            state_d = REQ;               // returned word is simply dropped
          end else begin
            drain_addr_d = pc_q;         // in-flight request must complete
            state_d      = DRAIN;
          end
        end
        DRAIN: begin
          // An ack arriving with the redirect already retires the old request.
          if (imem_ack) begin
            state_d = REQ;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = REQ;          // BOOT, FULL
      endcase
    end else begin
      case (state_q)
        BOOT: state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            pc_advance_s = 1'b1;
            if (!instr_valid_q || consume_s) begin
              instr_d       = imem_rdata;
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
            end else begin
              skid_load_s = 1'b1;
              state_d     = FULL;
            end
          end else begin
            state_d = REQ;
          end
        end
        FULL: begin
          if (consume_s) begin
            instr_d       = skid_instr_s;
            instr_pc_d    = skid_pc_s;
            instr_valid_d = skid_valid_s;
            skid_pop_s    = 1'b1;
            state_d       = REQ;
          end else begin
            state_d = FULL;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_d = REQ;               // discarded data never reaches the slot
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // State, PC and output slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      drain_addr_q  <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_out      = pc_q;

endmodule
